mem_arbiter: RTL

//  Two-port arbiter/sequencer in front of the 16x8 unified memory (sync write, registered read,

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter/sequencer in front of a 16x8 unified memory. The memory
//   writes synchronously, has a registered read, and updates data_out only on
//   read cycles. Port 0 is the CPU fetch/execute path. Port 1 is the program
//   loader/debug path. The arbiter picks one request and latches that op. It
//   then drives the memory pins and returns read data with a done pulse.
//
//   Sequence: IDLE -> ACCESS -> IDLE          (write, done at T+2)
//             IDLE -> ACCESS -> CAPTURE -> IDLE (read,  done at T+3)
//
//   Configuration macro:
//     MEM_ARB_RR_EN  defined   : round-robin between simultaneous requesters
//                    undefined : fixed priority, port 1 beats port 0
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req0/1, we0/1         request (held until gnt), 1 = write / 0 = read
//   addr0/1, wdata0/1     word address and write data per port
//   gnt0/1                one-cycle pulse in the ACCESS cycle of that port's op
//   done0/1               one-cycle pulse when the op completes
//   rdata                 data of the last completed read (held)
//   busy                  sequencer is not idle
//   mem_addr/wdata/we     memory pins (addr/wdata hold the last latched op)
//   mem_rdata             memory registered read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic any_req;
  logic win_port;   // port that wins if the sequencer accepts an op this cycle
  logic lat_port;
  logic lat_we;
  logic done0_nxt, done1_nxt;
  logic capture_rd;
  logic accept;

  assign any_req = req0 | req1;
  assign accept  = (state == IDLE) && any_req;

`ifdef MEM_ARB_RR_EN
  // The pointer holds the port granted last. When both ports request, the
  // other port wins. It resets to 0, so port 1 goes first after reset.
  logic last_port;

  always_comb begin
    if (req0 && req1) win_port = ~last_port;
    else              win_port = req1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_port <= 1'b0;
    else if (accept) last_port <= win_port;
  end
`else
  assign win_port = req1;
`endif

  // Latch the winning op when it is accepted. mem_addr and mem_wdata come
  // straight from this latch, so they hold their value between ops.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      lat_port  <= win_port;
      lat_we    <= win_port ? we1    : we0;
      mem_addr  <= win_port ? addr1  : addr0;
      mem_wdata <= win_port ? wdata1 : wdata0;
    end
  end

  // Next-state logic and outputs. gnt* and mem_we are decoded from the
  // state, so an asynchronous reset in ACCESS drops them at once.
  // NOTE: every signal gets a default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mem_we     = 1'b0;
    done0_nxt  = 1'b0;
    done1_nxt  = 1'b0;
    capture_rd = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        gnt0   = (lat_port == 1'b0);
        gnt1   = (lat_port == 1'b1);
        mem_we = lat_we;
        if (lat_we) begin
          state_nxt = IDLE;
          done0_nxt = (lat_port == 1'b0);
          done1_nxt = (lat_port == 1'b1);
        end else begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        // The memory produced mem_rdata at the ACCESS->CAPTURE edge.
        state_nxt  = IDLE;
        capture_rd = 1'b1;
        done0_nxt  = (lat_port == 1'b0);
        done1_nxt  = (lat_port == 1'b1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done0 <= 1'b0;
      done1 <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      done0 <= done0_nxt;
      done1 <= done1_nxt;
      if (capture_rd) rdata <= mem_rdata;
    end
  end

  assign busy = (state != IDLE);

endmodule
